// File: rtl/monte_carlo_lanes.sv
// monte_carlo_lanes: LANES parallel xorshift32 samplers estimate the area under a line, then a restoring divider
// turns the hit count into a WIDTH-bit fraction. Define MONTE_CARLO_ABORT_EN to add the abort input.
module monte_carlo_lanes #(
    parameter int WIDTH  = 10,
    parameter int LANES  = 4,
    parameter int ITER_W = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
`ifdef MONTE_CARLO_ABORT_EN
    input  logic                            abort,
`endif
    input  logic [ITER_W-1:0]               num_of_iterations,
    input  logic [31:0]                     seed,
    input  logic [WIDTH-1:0]                a,
    input  logic [WIDTH-1:0]                b,
    output logic                            busy,
    output logic                            done,
    output logic [ITER_W+$clog2(LANES):0]   hits,
    output logic [WIDTH-1:0]                result
);

    localparam int DW  = ITER_W + $clog2(LANES);
    localparam int HW  = DW + 1;
    localparam int FW  = 2 * WIDTH + 1;
    localparam int DCW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DIV, DONE} state_t;

    state_t             state, state_next;
    logic [ITER_W-1:0]  n_reg;
    logic [WIDTH-1:0]   a_reg, b_reg;
    logic [ITER_W-1:0]  round_cnt;
    logic [HW-1:0]      acc, acc_sum, pop;
    logic [HW-1:0]      rem, trial;
    logic [DW-1:0]      divisor;
    logic               ge;
    logic [WIDTH:0]     quot;
    logic [DCW-1:0]     div_cnt;
    logic               last_round, last_div, abort_req;

    logic [31:0]        lane_s    [LANES];
    logic [31:0]        lane_adv  [LANES];
    logic [31:0]        lane_seed [LANES];
    logic [LANES-1:0]   lane_hit;

`ifdef MONTE_CARLO_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [WIDTH-1:0]   x, y, f;
        logic [2*WIDTH-1:0] prod;
        logic [FW-1:0]      f_wide;
        logic [31:0]        t1, t2, s0;

        assign x      = lane_s[g][WIDTH-1:0];
        assign y      = lane_s[g][2*WIDTH-1:WIDTH];
        assign prod   = {{WIDTH{1'b0}}, a_reg} * {{WIDTH{1'b0}}, x};
        assign f_wide = FW'(prod >> WIDTH) + FW'(b_reg);
        assign f      = (f_wide > FW'({WIDTH{1'b1}})) ? {WIDTH{1'b1}} : f_wide[WIDTH-1:0];
        assign lane_hit[g] = (y <= f);

        assign t1          = lane_s[g] ^ (lane_s[g] << 13);
        assign t2          = t1 ^ (t1 >> 17);
        assign lane_adv[g] = t2 ^ (t2 << 5);

        // A zero state would lock xorshift at zero forever.
        assign s0           = seed ^ (32'(g) * 32'h9E3779B9);
        assign lane_seed[g] = (s0 == 32'd0) ? 32'd1 : s0;
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < LANES; i++) begin
            pop = pop + HW'(lane_hit[i]);
        end
    end

    assign acc_sum    = acc + pop;
    assign divisor    = DW'(n_reg) * DW'(LANES);
    assign ge         = (rem >= {1'b0, divisor});
    assign trial      = ge ? (rem - {1'b0, divisor}) : rem;
    assign last_round = (round_cnt == (n_reg - ITER_W'(1)));
    assign last_div   = (div_cnt == DCW'(WIDTH));
    assign busy       = (state == RUN) || (state == DIV);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = (num_of_iterations == '0) ? DONE : RUN;
            RUN: begin
                if (abort_req)       state_next = IDLE;
                else if (last_round) state_next = DIV;
            end
            DIV: begin
                if (abort_req)     state_next = IDLE;
                else if (last_div) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The remainder starts as the raw hit count; hits <= samples keeps the quotient within WIDTH+1 bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            n_reg     <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            round_cnt <= '0;
            acc       <= '0;
            rem       <= '0;
            quot      <= '0;
            div_cnt   <= '0;
            done      <= 1'b0;
            hits      <= '0;
            result    <= '0;
            for (int i = 0; i < LANES; i++) begin
                lane_s[i] <= '0;
            end
        end else begin
            state <= state_next;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        n_reg     <= num_of_iterations;
                        a_reg     <= a;
                        b_reg     <= b;
                        acc       <= '0;
                        round_cnt <= '0;
                        quot      <= '0;
                        for (int i = 0; i < LANES; i++) begin
                            lane_s[i] <= lane_seed[i];
                        end
                    end
                end
                RUN: begin
                    if (!abort_req) begin
                        acc       <= acc_sum;
                        round_cnt <= round_cnt + ITER_W'(1);
                        for (int i = 0; i < LANES; i++) begin
                            lane_s[i] <= lane_adv[i];
                        end
                        if (last_round) begin
                            rem     <= acc_sum;
                            div_cnt <= '0;
                        end
                    end
                end
                DIV: begin
                    if (!abort_req) begin
                        rem     <= {trial[HW-2:0], 1'b0};
                        quot    <= {quot[WIDTH-1:0], ge};
                        div_cnt <= div_cnt + DCW'(1);
                    end
                end
                DONE: begin
                    done   <= 1'b1;
                    hits   <= acc;
                    result <= quot[WIDTH] ? {WIDTH{1'b1}} : quot[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_monte_carlo_lanes.sv
// Directed self-checking bench for monte_carlo_lanes; expected hits/result come from a behavioural xorshift model.
module tb_monte_carlo_lanes;

    localparam int WIDTH  = 10;
    localparam int LANES  = 4;
    localparam int ITER_W = 16;
    localparam int HW     = ITER_W + $clog2(LANES) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ITER_W-1:0] num_of_iterations;
    logic [31:0]       seed;
    logic [WIDTH-1:0]  a, b;
    logic              busy, done;
    logic [HW-1:0]     hits;
    logic [WIDTH-1:0]  result;
`ifdef MONTE_CARLO_ABORT_EN
    logic              abort = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    monte_carlo_lanes #(.WIDTH(WIDTH), .LANES(LANES), .ITER_W(ITER_W)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
`ifdef MONTE_CARLO_ABORT_EN
        .abort(abort),
`endif
        .num_of_iterations(num_of_iterations),
        .seed(seed),
        .a(a),
        .b(b),
        .busy(busy),
        .done(done),
        .hits(hits),
        .result(result)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] xsNext(input logic [31:0] s);
        logic [31:0] t;
        t = s ^ (s << 13);
        t = t ^ (t >> 17);
        return t ^ (t << 5);
    endfunction

    function automatic int modelHits(input logic [31:0] sd, input int n, input int ca, input int cb);
        int total;
        total = 0;
        for (int lane = 0; lane < LANES; lane++) begin
            logic [31:0] s;
            s = sd ^ (32'(lane) * 32'h9E3779B9);
            if (s == 32'd0) s = 32'd1;
            for (int k = 0; k < n; k++) begin
                int x, y, f;
                x = int'(s[9:0]);
                y = int'(s[19:10]);
                f = (ca * x) / 1024 + cb;
                if (f > 1023) f = 1023;
                if (y <= f) total++;
                s = xsNext(s);
            end
        end
        return total;
    endfunction

    function automatic int modelResult(input int h, input int n);
        longint q;
        if (n == 0) return 0;
        q = (longint'(h) * 1024) / longint'(n * LANES);
        if (q > 1023) q = 1023;
        return int'(q);
    endfunction

    // Returns on the edge index E0 sits at, with start already dropped.
    task automatic applyStimulus(input int n, input int ca, input int cb, input logic [31:0] sd);
        @(negedge clk);
        num_of_iterations = ITER_W'(n);
        a     = WIDTH'(ca);
        b     = WIDTH'(cb);
        seed  = sd;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input int budget, output int edges, output bit busySeen);
        edges    = 0;
        busySeen = 1'b0;
        while (edges < budget) begin
            @(posedge clk);
            #1;
            edges++;
            if (busy) busySeen = 1'b1;
            if (done) return;
        end
        edges = -1;
    endtask

    initial begin
        int  edges, expHits, expRes, prevHits, prevRes;
        bit  busySeen, doneSeen;

        rst = 1'b0; start = 1'b0; num_of_iterations = '0; seed = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_hits", hits, 0);
        checkOutput("reset_result", result, 0);
        @(negedge clk);
        rst = 1'b1;
        doneSeen = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (done) doneSeen = 1'b1;
        end
        checkOutput("idle_no_done", doneSeen, 0);

        $display("[TB] full hit run");
        applyStimulus(1000, 0, 1023, 32'd20);
        checkOutput("full_busy_after_e0", busy, 1);
        waitDone(1100, edges, busySeen);
        checkOutput("full_done_edge", edges, 1012);
        checkOutput("full_hits", hits, 4000);
        checkOutput("full_result", result, 1023);

        $display("[TB] half area run");
        expHits = modelHits(32'd20, 1000, 1023, 0);
        expRes  = modelResult(expHits, 1000);
        applyStimulus(1000, 1023, 0, 32'd20);
        waitDone(1100, edges, busySeen);
        checkOutput("half_done_edge", edges, 1012);
        checkOutput("half_hits", hits, 64'(expHits));
        checkOutput("half_result", result, 64'(expRes));
        checkOutput("half_in_range", (result >= 471 && result <= 551), 1);

        $display("[TB] zero iterations");
        applyStimulus(0, 100, 100, 32'd3);
        checkOutput("zero_busy_after_e0", busy, 0);
        waitDone(20, edges, busySeen);
        checkOutput("zero_done_edge", edges, 1);
        checkOutput("zero_busy_seen", busySeen, 0);
        checkOutput("zero_hits", hits, 0);
        checkOutput("zero_result", result, 0);

        $display("[TB] start while busy is ignored");
        expHits = modelHits(32'hDEADBEEF, 300, 600, 100);
        expRes  = modelResult(expHits, 300);
        applyStimulus(300, 600, 100, 32'hDEADBEEF);
        repeat (49) @(posedge clk);
        #1;
        start = 1'b1; seed = 32'd1; num_of_iterations = ITER_W'(5); a = '0; b = 10'd1023;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("busy_start_busy", busy, 1);
        waitDone(400, edges, busySeen);
        checkOutput("busy_start_done_edge", (edges < 0) ? -1 : edges + 50, 312);
        checkOutput("busy_start_hits", hits, 64'(expHits));
        checkOutput("busy_start_result", result, 64'(expRes));
        repeat (5) @(posedge clk);
        #1;
        checkOutput("hold_done_low", done, 0);
        checkOutput("hold_hits", hits, 64'(expHits));
        checkOutput("hold_result", result, 64'(expRes));

        $display("[TB] reset mid-run");
        applyStimulus(1000, 1023, 0, 32'd99);
        repeat (499) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_done", done, 0);
        checkOutput("midrst_hits", hits, 0);
        checkOutput("midrst_result", result, 0);
        @(negedge clk);
        rst = 1'b1;

        expHits = modelHits(32'd7, 200, 300, 400);
        expRes  = modelResult(expHits, 200);
        applyStimulus(200, 300, 400, 32'd7);
        waitDone(300, edges, busySeen);
        checkOutput("post_rst_done_edge", edges, 212);
        checkOutput("post_rst_hits", hits, 64'(expHits));
        checkOutput("post_rst_result", result, 64'(expRes));
        prevHits = expHits;
        prevRes  = expRes;

`ifdef MONTE_CARLO_ABORT_EN
        $display("[TB] abort in DIV");
        applyStimulus(20, 500, 200, 32'd5);
        repeat (22) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        checkOutput("abort_busy_low", busy, 0);
        doneSeen = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done) doneSeen = 1'b1;
        end
        checkOutput("abort_no_done", doneSeen, 0);
        checkOutput("abort_hits_kept", hits, 64'(prevHits));
        checkOutput("abort_result_kept", result, 64'(prevRes));
`else
        checkOutput("final_hits_kept", hits, 64'(prevHits));
        checkOutput("final_result_kept", result, 64'(prevRes));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
